// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: fully pipelined log-shifter with valid/ready handshake.
// One mux stage per shift-amount bit, largest shift first, each stage
// registered. A single global advance moves or freezes the entire pipe.
// Optional macro BARREL_SHIFTER_PIPE_ROTATE_EN adds rotate-right on mode 11;
// without it mode 11 is a plain logical right shift.

// One pipeline stage: conditional shift by SHAMT, then the stage register.
module bsp_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 5,
  parameter int SHAMT       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic [1:0]             in_mode,
  input  logic                   in_fill,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic [1:0]             out_mode,
  output logic                   out_fill
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] stage_data;

  // Shift candidate for this stage; the MSB of in_shift is this stage's select.
  always_comb begin
    shifted = in_data;
    if (in_mode == 2'b00) begin
      shifted = in_data << SHAMT;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    end else if (in_mode == 2'b11) begin
      // Wrap bits come from this stage's own data.
      shifted = {in_data[SHAMT-1:0], in_data[DATA_WIDTH-1:SHAMT]};
`endif
    end else begin
      // Fill bit was captured at entry and is never re-derived here.
      shifted = {{SHAMT{in_fill}}, in_data[DATA_WIDTH-1:SHAMT]};
    end
    stage_data = in_shift[SHIFT_WIDTH-1] ? shifted : in_data;
  end

  // Stage register; the consumed shift bit is dropped so the next stage
  // always reads its select from the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_mode  <= 2'b00;
      out_fill  <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= stage_data;
      out_shift <= {in_shift[SHIFT_WIDTH-2:0], 1'b0};
      out_mode  <= in_mode;
      out_fill  <= in_fill;
    end
  end

endmodule

module barrel_shifter_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic [1:0]             i_mode,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_data
);

  localparam int STAGES = SHIFT_WIDTH;

  // Index 0 is the live input; index k+1 is the register after stage k.
  logic [STAGES:0]                  vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0]  data_pipe;
  logic [STAGES:0][SHIFT_WIDTH-1:0] shift_pipe;
  logic [STAGES:0][1:0]             mode_pipe;
  logic [STAGES:0]                  fill_pipe;
  logic                             adv;
  logic                             unused_tail;

  // Whole pipe moves together whenever the output slot is free or drained.
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  // Entry: fill is the sign bit only for ASR.
  assign vld_pipe[0]   = i_valid;
  assign data_pipe[0]  = i_data;
  assign shift_pipe[0] = i_shift;
  assign mode_pipe[0]  = i_mode;
  assign fill_pipe[0]  = (i_mode == 2'b10) & i_data[DATA_WIDTH-1];

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      bsp_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .SHAMT      (1 << (STAGES - 1 - k))
      ) u_stage (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .adv      (adv),
        .in_valid (vld_pipe[k]),
        .in_data  (data_pipe[k]),
        .in_shift (shift_pipe[k]),
        .in_mode  (mode_pipe[k]),
        .in_fill  (fill_pipe[k]),
        .out_valid(vld_pipe[k+1]),
        .out_data (data_pipe[k+1]),
        .out_shift(shift_pipe[k+1]),
        .out_mode (mode_pipe[k+1]),
        .out_fill (fill_pipe[k+1])
      );
    end
  endgenerate

  // Outputs straight from the last register: no input-to-output comb path.
  assign o_valid = vld_pipe[STAGES];
  assign o_data  = data_pipe[STAGES];

  // Control fields of the final register have no consumer.
  assign unused_tail = ^{shift_pipe[STAGES], mode_pipe[STAGES], fill_pipe[STAGES]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe at widths 32, 8 and 64.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, r32o, ov32, ir32;
  logic [31:0] d32, od32;
  logic [4:0]  s32;
  logic [1:0]  m32;

  logic        v8, r8o, ov8, ir8;
  logic [7:0]  d8, od8;
  logic [2:0]  s8;
  logic [1:0]  m8;

  logic        v64, r64o, ov64, ir64;
  logic [63:0] d64, od64;
  logic [5:0]  s64;
  logic [1:0]  m64;

  int checks = 0;
  int errors = 0;

  barrel_shifter_pipe #(.DATA_WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(r32o), .i_data(d32),
    .i_shift(s32), .i_mode(m32), .o_valid(ov32), .i_ready(ir32), .o_data(od32));
  barrel_shifter_pipe #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(r8o), .i_data(d8),
    .i_shift(s8), .i_mode(m8), .o_valid(ov8), .i_ready(ir8), .o_data(od8));
  barrel_shifter_pipe #(.DATA_WIDTH(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v64), .o_ready(r64o), .i_data(d64),
    .i_shift(s64), .i_mode(m64), .o_valid(ov64), .i_ready(ir64), .o_data(od64));

  // Behavioural reference on a w-bit operand held in 64 bits.
  function automatic logic [63:0] model(input logic [63:0] din, input int sh,
                                        input logic [1:0] mode, input int w);
    logic [63:0] mask, d, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = din & mask;
    case (mode)
      2'b00: r = (d << sh) & mask;
      2'b10: begin
        r = d >> sh;
        if (d[w-1]) r = r | (mask & ~(mask >> sh));
      end
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
      2'b11: r = ((d >> sh) | (d << (w - sh))) & mask;
`endif
      default: r = d >> sh;
    endcase
    return r;
  endfunction

  // One operand through the 32-bit DUT; lat counts edges from the transfer edge (=1).
  task automatic run_single(input logic [31:0] din, input int sh, input logic [1:0] mode,
                            output logic [31:0] got, output int lat);
    @(posedge clk); #1;
    ir32 = 1'b1; v32 = 1'b1; d32 = din; s32 = 5'(sh); m32 = mode;
    @(posedge clk);
    lat = 1;
    #1 v32 = 1'b0;
    while (!ov32 && lat < 20) begin
      @(posedge clk); lat++; #1;
    end
    got = od32;
  endtask

  task automatic test_reset;
    v32 = 0; ir32 = 0; d32 = '0; s32 = '0; m32 = '0;
    v8 = 0;  ir8 = 0;  d8 = '0;  s8 = '0;  m8 = '0;
    v64 = 0; ir64 = 0; d64 = '0; s64 = '0; m64 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", ov32); end
    checks++; if (od32 !== 32'h0) begin errors++; $display("FAIL reset_o_data got=%h exp=0", od32); end
    checks++; if (r32o !== 1'b1) begin errors++; $display("FAIL reset_o_ready got=%b exp=1", r32o); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0 || r32o !== 1'b1 || ov8 !== 1'b0 || ov64 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset o_valid=%b o_ready=%b exp 0/1", ov32, r32o);
    end
  endtask

  task automatic test_modes;
    logic [31:0] vd [4] = '{32'h0000_00F1, 32'h8000_0000, 32'h8000_0000, 32'h7000_0000};
    int          vs [4] = '{4, 31, 31, 4};
    logic [1:0]  vm [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [31:0] ve [4] = '{32'h0000_0F10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0700_0000};
    logic [31:0] got;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_single(vd[i], vs[i], vm[i], got, lat);
      checks++;
      if (lat != 5) begin errors++; $display("FAIL mode%0d_latency got=%0d exp=5", i, lat); end
      checks++;
      if (got !== ve[i]) begin errors++; $display("FAIL mode%0d_data got=%h exp=%h", i, got, ve[i]); end
    end
  endtask

  task automatic test_rotate;
    logic [31:0] got, exp;
    int lat;
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
    exp = 32'h8000_0000;
`else
    exp = 32'h0000_0000;
`endif
    run_single(32'h0000_0001, 1, 2'b11, got, lat);
    checks++;
    if (got !== exp || lat != 5) begin
      errors++; $display("FAIL rotate got=%h lat=%0d exp=%h lat=5", got, lat, exp);
    end
  endtask

  task automatic test_reset_midflight;
    int seen = 0;
    @(posedge clk); #1;
    ir32 = 1'b1; v32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d32 = 32'(i + 1); s32 = 5'd1; m32 = 2'b00;
      @(posedge clk); #1;
    end
    v32 = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_midflight outputs=%0d exp=0", seen); end
  endtask

  // Random traffic on the 32-bit DUT with i_ready asserted rdy_pct% of cycles.
  task automatic test_traffic(input int n, input int rdy_pct);
    logic [31:0] exp_q[$];
    logic [31:0] held_data = '0, e;
    logic [63:0] m;
    bit held = 0;
    int sent = 0, got = 0, cyc = 0, first_out = -1, last_out = -1;
    while ((sent < n || exp_q.size() > 0) && cyc < n * 20 + 50) begin
      @(posedge clk); #1;
      if (held) begin
        checks++;
        if (ov32 !== 1'b1 || od32 !== held_data) begin
          errors++; $display("FAIL stall_hold got=%b/%h exp=1/%h", ov32, od32, held_data);
        end
      end
      ir32 = ($urandom_range(99) < rdy_pct);
      if (sent < n) begin
        v32 = 1'b1; d32 = $urandom; s32 = 5'($urandom_range(31)); m32 = 2'($urandom_range(3));
      end else v32 = 1'b0;
      #1;
      checks++;
      if (r32o !== (~ov32 | ir32)) begin
        errors++; $display("FAIL o_ready_rule got=%b exp=%b", r32o, ~ov32 | ir32);
      end
      if (rdy_pct == 100) begin
        checks++;
        if (r32o !== 1'b1) begin errors++; $display("FAIL stream_o_ready got=%b exp=1", r32o); end
      end
      if (ov32 && ir32) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_output got=%h exp=none", od32);
        end else begin
          e = exp_q.pop_front();
          if (od32 !== e) begin errors++; $display("FAIL stream_data idx=%0d got=%h exp=%h", got, od32, e); end
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      held = ov32 && !ir32;
      held_data = od32;
      if (v32 && r32o) begin
        m = model({32'd0, d32}, int'(s32), m32, 32);
        exp_q.push_back(m[31:0]);
        sent++;
      end
      cyc++;
    end
    v32 = 1'b0; ir32 = 1'b1;
    checks++;
    if (got != n) begin errors++; $display("FAIL traffic_count got=%0d exp=%0d", got, n); end
    if (rdy_pct == 100) begin
      checks++;
      if (last_out - first_out != n - 1) begin
        errors++; $display("FAIL stream_rate span=%0d exp=%0d", last_out - first_out, n - 1);
      end
    end
  endtask

  task automatic test_width8;
    logic [7:0] exp_q[$];
    int sh_q[$];
    logic [63:0] m;
    logic [7:0] e;
    int i = 0, cyc = 0, got = 0, tx_cyc = -1, lat = -1, shv;
    ir8 = 1'b1;
    while ((i < 32 || exp_q.size() > 0) && cyc < 300) begin
      @(posedge clk); #1;
      if (ov8) begin
        if (lat < 0) lat = cyc - tx_cyc;
        checks++;
        e = exp_q.pop_front(); shv = sh_q.pop_front(); got++;
        if (od8 !== e) begin errors++; $display("FAIL w8_data shift=%0d got=%h exp=%h", shv, od8, e); end
        if (shv == 0) begin
          checks++;
          if (od8 !== 8'h81) begin errors++; $display("FAIL w8_shift0 got=%h exp=81", od8); end
        end
      end
      if (i < 32) begin v8 = 1'b1; d8 = 8'h81; m8 = 2'(i / 8); s8 = 3'(i % 8); end
      else v8 = 1'b0;
      #1;
      if (v8 && r8o) begin
        m = model(64'h81, i % 8, m8, 8);
        exp_q.push_back(m[7:0]); sh_q.push_back(i % 8);
        if (tx_cyc < 0) tx_cyc = cyc;
        i++;
      end
      cyc++;
    end
    v8 = 1'b0;
    checks++;
    if (got != 32 || lat != 3) begin errors++; $display("FAIL w8_count_lat got=%0d/%0d exp=32/3", got, lat); end
  endtask

  task automatic test_width64;
    logic [63:0] exp_q[$];
    int sh_q[$];
    logic [63:0] pat = 64'h8000_0000_0000_0001, e;
    int i = 0, cyc = 0, got = 0, tx_cyc = -1, lat = -1, shv;
    ir64 = 1'b1;
    while ((i < 256 || exp_q.size() > 0) && cyc < 1000) begin
      @(posedge clk); #1;
      if (ov64) begin
        if (lat < 0) lat = cyc - tx_cyc;
        checks++;
        e = exp_q.pop_front(); shv = sh_q.pop_front(); got++;
        if (od64 !== e) begin errors++; $display("FAIL w64_data shift=%0d got=%h exp=%h", shv, od64, e); end
        if (shv == 0) begin
          checks++;
          if (od64 !== pat) begin errors++; $display("FAIL w64_shift0 got=%h exp=%h", od64, pat); end
        end
      end
      if (i < 256) begin v64 = 1'b1; d64 = pat; m64 = 2'(i / 64); s64 = 6'(i % 64); end
      else v64 = 1'b0;
      #1;
      if (v64 && r64o) begin
        exp_q.push_back(model(pat, i % 64, m64, 64)); sh_q.push_back(i % 64);
        if (tx_cyc < 0) tx_cyc = cyc;
        i++;
      end
      cyc++;
    end
    v64 = 1'b0;
    checks++;
    if (got != 256 || lat != 6) begin errors++; $display("FAIL w64_count_lat got=%0d/%0d exp=256/6", got, lat); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_rotate();
    test_reset_midflight();
    test_traffic(100, 100);
    test_traffic(200, 50);
    test_width8();
    test_width64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, fully pipelined barrel shifter with a valid/ready handshake. It supports logical left, logical right and arithmetic right shifts, plus an optional rotate-right mode. It is the next-generation shifter for the sin/cos generator datapath, used for CORDIC and scaling shifts where the combinational 32/16-bit shifters cannot meet timing. It accepts one operand per cycle, has fixed latency, and applies full back-pressure.

## Interface
- DATA_WIDTH, 32, operand width; power of two, 4..64
- SHIFT_WIDTH, $clog2(DATA_WIDTH), shift-amount width; derived, do not override
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input operand valid
- o_ready  out  1  block can accept an input this cycle
- i_data  in  DATA_WIDTH  operand
- i_shift  in  SHIFT_WIDTH  shift amount, 0..DATA_WIDTH-1
- i_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (see Configuration)
- o_valid  out  1  output result valid
- i_ready  in  1  downstream accepts the result
- o_data  out  DATA_WIDTH  shifted result

## Operation
- The datapath has SHIFT_WIDTH mux stages. Stage k (k=0..SHIFT_WIDTH-1) applies a shift of 2^(SHIFT_WIDTH-1-k) when i_shift bit [SHIFT_WIDTH-1-k] is set, so the largest shift is applied first.
- Every stage is followed by a register holding: a valid bit, data, the remaining shift bits, the mode, and the fill bit.
- Fill bit is captured at stage 0:
  - ASR: i_data[DATA_WIDTH-1].
  - LSL/LSR: 0.
  - The fill bit is carried down the pipe. Later stages never re-derive it from partially shifted data.
- LSL shifts toward the MSB and zero-fills the LSBs. LSR/ASR shift toward the LSB and fill the MSBs with the fill bit. ROR wraps the LSBs into the MSBs.
- Shift 0 passes i_data unchanged in every mode.
- Global advance: adv = ~o_valid | i_ready.
  - When adv=1, all stage registers shift by one, and stage 0 loads {i_valid, operand}.
  - When adv=0, all registers hold.
- o_ready = adv (combinational). An input is transferred when i_valid & o_ready.
- Bubbles (invalid stages) are not compressed. A stalled pipe holds bubbles in place.
- o_data/o_valid come directly from the last stage register. There is no combinational path from i_data to o_data.
- o_data is held stable while o_valid=1 and i_ready=0.
- Width rule: all stages are DATA_WIDTH wide. Bits shifted out are discarded, with no carry/sticky output.

## Timing
- Reset (async assert, synchronous-safe deassert at the source):
  - All valid bits clear; o_valid=0; o_data=0; stage data regs=0.
  - o_ready=1 immediately after reset, since adv=~o_valid.
- Reset mid-operation: all in-flight operands are discarded. No output is produced for them after release.
- Latency: L = SHIFT_WIDTH cycles from the input transfer edge to o_valid, provided there is no stall. With DATA_WIDTH=32, L=5.
- Throughput: 1 result/cycle while i_ready=1.
- Stall: i_ready=0 with o_valid=1 freezes the whole pipe in the same cycle, and o_ready drops combinationally.
- Simultaneous i_valid, i_ready and o_valid: the output is accepted and a new input is accepted on the same edge.
- i_ready=0 with o_valid=0 does not stall the pipe; the pipe keeps filling.

## Configuration
- Macro BARREL_SHIFTER_PIPE_ROTATE_EN.
- Defined:
  - i_mode=11 performs rotate-right by i_shift.
  - Each stage's rotate path uses the stage's own data for wrap bits.
- Undefined:
  - No rotate muxes are synthesised.
  - i_mode=11 behaves exactly as LSR (fill 0).
- The handshake and latency are identical in both builds.

## Test plan
- Reset/idle, DATA_WIDTH=32: i_rst_n low then high, no stimulus.
  - Expect o_valid=0, o_data=0, o_ready=1.
  - Asserting i_rst_n low while 3 operands are in flight: none of them emerges after release.
- Modes, DATA_WIDTH=32:
  - LSL: i_data=0x0000_00F1, shift=4 → o_data=0x0000_0F10, valid exactly 5 cycles after transfer.
  - LSR: i_data=0x8000_0000, shift=31 → 0x0000_0001.
  - ASR: i_data=0x8000_0000, shift=31 → 0xFFFF_FFFF.
  - ASR: i_data=0x7000_0000, shift=4 → 0x0700_0000.
- Streaming: 100 back-to-back random operands/modes with i_ready=1.
  - Expect results in order, 1 per cycle, matching the reference model.
  - Expect o_ready constantly 1.
- Back-pressure: random i_ready toggling (50%).
  - No result lost or duplicated.
  - o_data stable while o_valid & ~i_ready.
  - o_ready == (~o_valid | i_ready) every cycle.
- Rotate: i_data=0x0000_0001, shift=1, mode=11.
  - With BARREL_SHIFTER_PIPE_ROTATE_EN defined: o_data=0x8000_0000.
  - Undefined: o_data=0x0000_0000.
- Width sweep: DATA_WIDTH=8 (L=3) and 64 (L=6).
  - All shifts 0..DATA_WIDTH-1 for each mode on 0x80…01 patterns match the model.
  - Shift 0 returns the input unchanged.
